// File: rtl/addsub_pkg.sv
// Shared types for the add/sub inverse: FSM states, operand-select encoding and default width.
package addsub_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        SUB_YA,
        SUB_AM,
        ADD_AM
    } opsel_t;

endpackage

// File: rtl/addsub_inverse_serial_fulladder.sv
// One-bit full adder slice; the inverse unit reuses it as its single serial stage.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic d,
    output logic s,
    output logic c
);

    assign s = a ^ b ^ d;
    assign c = (a & b) | (d & (a ^ b));

endmodule

// File: rtl/addsub_inverse_serial.sv
// Bit-serial inverse of the add/sub unit: recovers B from m, A and the (WIDTH+1)-bit result.
// Error detection is compiled in only when ADDSUB_INV_ERR_EN is defined.
module addsub_inverse_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             m,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH:0]   yp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] b_out,
    output logic             err
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

    state_t           state, state_nxt;
    opsel_t           opsel;
    logic [CNT_W-1:0] count;
    logic [WIDTH:0]   xsh, ysh;
    logic [WIDTH-1:0] rsh;
    logic             carry;
    logic             ybit, fa_s, fa_c;
    logic             err_nxt;
    logic [WIDTH-1:0] b_nxt;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Subtraction feeds the inverted Y bit with the carry preloaded to 1.
    assign ybit = (opsel == ADD_AM) ? ysh[0] : ~ysh[0];

    fulladder u_fa (
        .a (xsh[0]),
        .b (ybit),
        .d (carry),
        .s (fa_s),
        .c (fa_c)
    );

`ifdef ADDSUB_INV_ERR_EN
    logic mag_zero;
    logic err_q;

    // On the final slice fa_s is result bit WIDTH and fa_c is the borrow-free carry.
    always_comb begin
        err_nxt = 1'b0;
        if (opsel == ADD_AM)
            err_nxt = fa_s | mag_zero;
        else
            err_nxt = fa_s | ~fa_c;
    end

    assign b_nxt = err_nxt ? '0 : rsh;
    assign err   = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mag_zero <= 1'b0;
            err_q    <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            mag_zero <= (yp[WIDTH-1:0] == '0);
        end else if (state == CALC && count == LAST) begin
            err_q <= err_nxt;
        end
    end
`else
    assign err_nxt = 1'b0;
    assign b_nxt   = rsh;
    assign err     = err_nxt;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = CALC;
            CALC:    if (count == LAST) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opsel <= SUB_YA;
            count <= '0;
            xsh   <= '0;
            ysh   <= '0;
            rsh   <= '0;
            carry <= 1'b0;
            b_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        count <= '0;
                        if (!m) begin
                            xsh   <= yp;
                            ysh   <= {1'b0, a};
                            opsel <= SUB_YA;
                            carry <= 1'b1;
                        end else if (!yp[WIDTH]) begin
                            xsh   <= {1'b0, a};
                            ysh   <= {1'b0, yp[WIDTH-1:0]};
                            opsel <= SUB_AM;
                            carry <= 1'b1;
                        end else begin
                            xsh   <= {1'b0, a};
                            ysh   <= {1'b0, yp[WIDTH-1:0]};
                            opsel <= ADD_AM;
                            carry <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    carry <= fa_c;
                    xsh   <= xsh >> 1;
                    ysh   <= ysh >> 1;
                    count <= count + 1'b1;
                    // The last slice produces bit WIDTH, which only feeds the error check.
                    if (count == LAST)
                        b_out <= b_nxt;
                    else
                        rsh <= {fa_s, rsh[WIDTH-1:1]};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_inverse_serial.sv
// Scoreboard bench for addsub_inverse_serial; expectations adapt to ADDSUB_INV_ERR_EN.
module tb_addsub_inverse_serial;

    localparam int W = 4;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n, in_valid, in_ready, m, out_valid, out_ready, err;
    logic [W-1:0] a, b_out;
    logic [W:0]   yp;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int acc_cyc = 0;

    typedef struct packed {
        logic [W-1:0] b;
        logic         e;
    } exp_t;

    exp_t sb[$];

    addsub_inverse_serial #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .m         (m),
        .a         (a),
        .yp        (yp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .b_out     (b_out),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic mm, input logic [W-1:0] aa, input logic [W:0] yy);
        int   r;
        int   mag;
        logic bad;
        exp_t ex;
        mag = int'(yy[W-1:0]);
        if (!mm) begin
            r   = int'(yy) - int'(aa);
            bad = (r < 0) || (r > MAXV);
        end else if (!yy[W]) begin
            r   = int'(aa) - mag;
            bad = (r < 0);
        end else begin
            r   = int'(aa) + mag;
            bad = (r > MAXV) || (mag == 0);
        end
`ifdef ADDSUB_INV_ERR_EN
        ex.b = bad ? '0 : r[W-1:0];
        ex.e = bad;
`else
        ex.b = r[W-1:0];
        ex.e = 1'b0;
`endif
        return ex;
    endfunction

    function automatic logic [W:0] addsub(input logic mm, input logic [W-1:0] aa, input logic [W-1:0] bb);
        if (!mm)
            return {1'b0, aa} + {1'b0, bb};
        else if (aa >= bb)
            return {1'b0, aa - bb};
        else
            return {1'b1, bb - aa};
    endfunction

    task automatic send(input logic mm, input logic [W-1:0] aa, input logic [W:0] yy);
        int k;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
        end
        m = mm; a = aa; yp = yy; in_valid = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        sb.push_back(model(mm, aa, yy));
        in_valid = 1'b0;
        m  = 1'($urandom);
        a  = W'($urandom);
        yp = (W+1)'($urandom);
    endtask

    task automatic recv(output logic [W-1:0] ob, output logic oe, output int lat, output bit ok);
        ok = 1'b0;
        ob = '0; oe = 1'b0; lat = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            ob  = b_out;
            oe  = err;
            lat = cyc - acc_cyc;
            out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; m = 1'b0; a = '0; yp = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++;
        if (b_out !== '0) begin n_bad++; $display("FAIL reset_b_out: got %0d want 0", b_out); end
        n_cmp++;
        if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    endtask

    task automatic test_vectors(input string name, input logic [W+W+1:0] vec [3], input bit chk_lat);
        logic [W-1:0] ob;
        logic         oe;
        int           lat;
        bit           ok;
        exp_t         ex;
        for (int i = 0; i < 3; i++) begin
            send(vec[i][W+W+1], vec[i][W+W:W+1], vec[i][W:0]);
            recv(ob, oe, lat, ok);
            ex = sb.pop_front();
            n_cmp++;
            if (!ok) begin
                n_bad++;
                $display("FAIL %s_%0d_timeout: out_valid never rose", name, i);
            end else if ({ob, oe} !== {ex.b, ex.e}) begin
                n_bad++;
                $display("FAIL %s_%0d: b_out=%0d err=%b want b_out=%0d err=%b", name, i, ob, oe, ex.b, ex.e);
            end
            if (chk_lat && ok) begin
                n_cmp++;
                if (lat !== 5) begin n_bad++; $display("FAIL %s_%0d_latency: %0d edges want 5", name, i, lat); end
            end
        end
    endtask

    task automatic test_basic;
        logic [W+W+1:0] v [3];
        v[0] = {1'b0, 4'd5,  5'b01100};
        v[1] = {1'b1, 4'd9,  5'b00011};
        v[2] = {1'b1, 4'd3,  5'b10100};
        test_vectors("basic", v, 1'b1);
    endtask

    task automatic test_errors;
        logic [W+W+1:0] v [3];
        v[0] = {1'b0, 4'd9,  5'b00100};
        v[1] = {1'b1, 4'd3,  5'b10000};
        v[2] = {1'b1, 4'd12, 5'b10101};
        test_vectors("err", v, 1'b0);
    endtask

    task automatic test_backpressure;
        logic [W-1:0] cb;
        logic         ce;
        bit           ok;
        exp_t         ex;
        send(1'b0, 4'd5, 5'b01100);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1'b1; break; end
        end
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL bp_timeout: out_valid never rose"); end
        cb = b_out; ce = err;
        in_valid = 1'b1; m = 1'b1; a = 4'd1; yp = 5'b00001;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({out_valid, b_out, err, in_ready} !== {1'b1, cb, ce, 1'b0}) begin
                n_bad++;
                $display("FAIL bp_hold_%0d: out_valid=%b b_out=%0d err=%b in_ready=%b want 1 %0d %b 0",
                         k, out_valid, b_out, err, in_ready, cb, ce);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        ex = sb.pop_front();
        n_cmp++;
        if ({cb, ce} !== {ex.b, ex.e}) begin
            n_bad++;
            $display("FAIL bp_result: b_out=%0d err=%b want %0d %b", cb, ce, ex.b, ex.e);
        end
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid) ok = 1'b1;
        end
        n_cmp++;
        if (ok) begin n_bad++; $display("FAIL bp_ignored_req: out_valid=1 want 0"); end
    endtask

    task automatic test_reset_mid;
        logic [W-1:0] ob;
        logic         oe;
        int           lat;
        bit           ok;
        exp_t         ex;
        send(1'b1, 4'd9, 5'b00011);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        void'(sb.pop_front());
        @(negedge clk);
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_bad++;
            $display("FAIL midreset_ctrl: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        send(1'b1, 4'd3, 5'b10100);
        recv(ob, oe, lat, ok);
        ex = sb.pop_front();
        n_cmp++;
        if (!ok || {ob, oe} !== {ex.b, ex.e}) begin
            n_bad++;
            $display("FAIL midreset_fresh: ok=%b b_out=%0d err=%b want %0d %b", ok, ob, oe, ex.b, ex.e);
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] ob;
        logic         oe;
        int           lat;
        bit           ok;
        int           prev;
        prev = -1;
        for (int i = 0; i < 4; i++) begin
            send(1'b0, W'(i + 2), (W+1)'(i + 9));
            if (prev >= 0) begin
                n_cmp++;
                if (acc_cyc - prev !== 7) begin
                    n_bad++;
                    $display("FAIL b2b_spacing_%0d: %0d cycles want 7", i, acc_cyc - prev);
                end
            end
            prev = acc_cyc;
            recv(ob, oe, lat, ok);
            void'(sb.pop_front());
            n_cmp++;
            if (!ok || ob !== 4'd7 || oe !== 1'b0) begin
                n_bad++;
                $display("FAIL b2b_result_%0d: b_out=%0d err=%b want 7 0", i, ob, oe);
            end
        end
    endtask

    task automatic test_sweep;
        logic [W-1:0] ob;
        logic         oe;
        int           lat;
        bit           ok;
        exp_t         ex;
        for (int mm = 0; mm < 2; mm++) begin
            for (int aa = 0; aa <= MAXV; aa++) begin
                for (int bb = 0; bb <= MAXV; bb++) begin
                    send(1'(mm), W'(aa), addsub(1'(mm), W'(aa), W'(bb)));
                    recv(ob, oe, lat, ok);
                    ex = sb.pop_front();
                    n_cmp++;
                    if (!ok || ob !== W'(bb) || oe !== 1'b0 || {ob, oe} !== {ex.b, ex.e}) begin
                        n_bad++;
                        $display("FAIL sweep m=%0d a=%0d b=%0d: b_out=%0d err=%b want %0d 0", mm, aa, bb, ob, oe, bb);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
